reg_read_issue: RTL and testbench

Register-read / issue stage between instruction decode and execute. It drives the register-array read selects, merges same-cycle writeback data, and keeps a per-register scoreboard of outstanding writes. It holds decoded instructions until their sources are ready and their destination counter has room. It then registers the 64-bit operands into a valid/ready pipeline slot for the execute stage.

---
 rtl/reg_read_issue.sv | 156 +++++++++++++++
 tb/tb_reg_read_issue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_issue.sv
`default_nettype none
// ============================================================================
// Module   : reg_read_issue
// Purpose  : Register-read / issue stage. Drives register-array read selects,
//            bypasses same-cycle writeback data, tracks outstanding writes per
//            register and registers operands into a valid/ready slot for EX.
// Revision : 1.0 - initial release
// ============================================================================
module reg_read_issue #(
  parameter int CNT_W = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DEC_VALID,
  input  logic [4:0]  DEC_RS1_SEL,
  input  logic [4:0]  DEC_RS2_SEL,
  input  logic        DEC_RS1_USE,
  input  logic        DEC_RS2_USE,
  input  logic [4:0]  DEC_RD,
  input  logic        DEC_RD_VALID,
  output logic        DEC_READY,
  output logic [4:0]  RS1_SEL,
  output logic [4:0]  RS2_SEL,
  input  logic [63:0] RS1_DATAIN,
  input  logic [63:0] RS2_DATAIN,
  input  logic [63:0] DATA_IN,
  input  logic        RD_WB_VALID_MEM3_WB,
  input  logic [4:0]  RD_WB_MEM3_WB,
  input  logic        RETIRE_VALID,
  input  logic [4:0]  RETIRE_RD,
  input  logic        FLUSH,
  input  logic        EX_READY,
  output logic        EX_VALID,
  output logic [63:0] EX_RS1_DATA,
  output logic [63:0] EX_RS2_DATA,
  output logic [4:0]  EX_RD,
  output logic        EX_RD_VALID,
  output logic        SB_ERR
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic             ex_valid_q;
  logic [63:0]      ex_rs1_q;
  logic [63:0]      ex_rs2_q;
  logic [4:0]       ex_rd_q;
  logic             ex_rd_valid_q;
  logic             sb_err_q;

  logic [CNT_W-1:0] w_cnt [32];
  logic [31:0]      w_dret;
  logic [31:0]      w_dfl;
  logic [31:0]      w_err;
  logic             w_rd_en;
  logic             w_fire;
  logic             w_busy1;
  logic             w_busy2;
  logic             w_full;
  logic             w_slot_free;
  logic [CNT_W:0]   w_rem1;
  logic [CNT_W:0]   w_rem2;
  logic [63:0]      w_op1;
  logic [63:0]      w_op2;

  // x0 is never tracked, so its entries are tied off.
  assign w_cnt[0]  = '0;
  assign w_dret[0] = 1'b0;
  assign w_dfl[0]  = 1'b0;
  assign w_err[0]  = 1'b0;

  // A destination of x0 behaves as "no destination".
  assign w_rd_en = DEC_RD_VALID & (DEC_RD != 5'd0);

  for (genvar r = 1; r < 32; r++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W+1:0] w_sum;
    logic             w_inc;

    assign w_inc     = w_fire & w_rd_en & (DEC_RD == 5'(r));
    assign w_dret[r] = RETIRE_VALID & (RETIRE_RD == 5'(r));
    assign w_dfl[r]  = FLUSH & ex_valid_q & ex_rd_valid_q & (ex_rd_q == 5'(r));
    // Two extra bits: one for headroom, one as sign for underflow detection.
    assign w_sum     = (CNT_W+2)'(cnt_q) + (CNT_W+2)'(w_inc)
                     - (CNT_W+2)'(w_dret[r]) - (CNT_W+2)'(w_dfl[r]);
    assign w_err[r]  = |w_sum[CNT_W+1:CNT_W];
    assign cnt_d     = w_err[r] ? '0 : w_sum[CNT_W-1:0];
    assign w_cnt[r]  = cnt_q;

    // Outstanding-write counter for register r.
    always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

  // A source is busy unless every outstanding write retires this very cycle.
  assign w_rem1  = (CNT_W+1)'(w_cnt[DEC_RS1_SEL]) - (CNT_W+1)'(w_dret[DEC_RS1_SEL])
                 - (CNT_W+1)'(w_dfl[DEC_RS1_SEL]);
  assign w_rem2  = (CNT_W+1)'(w_cnt[DEC_RS2_SEL]) - (CNT_W+1)'(w_dret[DEC_RS2_SEL])
                 - (CNT_W+1)'(w_dfl[DEC_RS2_SEL]);
  assign w_busy1 = DEC_RS1_USE & (DEC_RS1_SEL != 5'd0) & (w_rem1 != '0);
  assign w_busy2 = DEC_RS2_USE & (DEC_RS2_SEL != 5'd0) & (w_rem2 != '0);

  // Raw count only: a retire this cycle does not free a slot until next cycle.
  assign w_full      = w_rd_en & (w_cnt[DEC_RD] == c_CNT_MAX);
  assign w_slot_free = ~ex_valid_q | EX_READY;

  assign DEC_READY = ~RST & ~FLUSH & w_slot_free & ~w_busy1 & ~w_busy2 & ~w_full;
  assign w_fire    = DEC_VALID & DEC_READY;

  assign RS1_SEL = DEC_RS1_SEL;
  assign RS2_SEL = DEC_RS2_SEL;

  // Writeback bypass; x0 always comes from the array, which returns zero.
  assign w_op1 = (DEC_RS1_USE & RD_WB_VALID_MEM3_WB & (RD_WB_MEM3_WB == DEC_RS1_SEL)
                  & (DEC_RS1_SEL != 5'd0)) ? DATA_IN : RS1_DATAIN;
  assign w_op2 = (DEC_RS2_USE & RD_WB_VALID_MEM3_WB & (RD_WB_MEM3_WB == DEC_RS2_SEL)
                  & (DEC_RS2_SEL != 5'd0)) ? DATA_IN : RS2_DATAIN;

  // Output slot: flush beats issue, issue beats drain; data moves only on issue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid_q    <= 1'b0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_rd_valid_q <= 1'b0;
    end else if (FLUSH) begin
      ex_valid_q    <= 1'b0;
    end else if (w_fire) begin
      ex_valid_q    <= 1'b1;
      ex_rs1_q      <= w_op1;
      ex_rs2_q      <= w_op2;
      ex_rd_q       <= DEC_RD;
      ex_rd_valid_q <= w_rd_en;
    end else if (EX_READY) begin
      ex_valid_q    <= 1'b0;
    end
  end

  // Sticky flag for any counter underflow; only reset clears it.
  always_ff @(posedge CLK) begin
    if (RST) sb_err_q <= 1'b0;
    else     sb_err_q <= sb_err_q | (|w_err);
  end

  assign EX_VALID    = ex_valid_q;
  assign EX_RS1_DATA = ex_rs1_q;
  assign EX_RS2_DATA = ex_rs2_q;
  assign EX_RD       = ex_rd_q;
  assign EX_RD_VALID = ex_rd_valid_q;
  assign SB_ERR      = sb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_read_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_read_issue
// Purpose  : Directed self-checking bench for reg_read_issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_read_issue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        DEC_VALID;
  logic [4:0]  DEC_RS1_SEL, DEC_RS2_SEL;
  logic        DEC_RS1_USE, DEC_RS2_USE;
  logic [4:0]  DEC_RD;
  logic        DEC_RD_VALID;
  logic        DEC_READY;
  logic [4:0]  RS1_SEL, RS2_SEL;
  logic [63:0] RS1_DATAIN, RS2_DATAIN, DATA_IN;
  logic        RD_WB_VALID_MEM3_WB;
  logic [4:0]  RD_WB_MEM3_WB;
  logic        RETIRE_VALID;
  logic [4:0]  RETIRE_RD;
  logic        FLUSH;
  logic        EX_READY;
  logic        EX_VALID;
  logic [63:0] EX_RS1_DATA, EX_RS2_DATA;
  logic [4:0]  EX_RD;
  logic        EX_RD_VALID;
  logic        SB_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  reg_read_issue #(.CNT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .DEC_VALID(DEC_VALID), .DEC_RS1_SEL(DEC_RS1_SEL), .DEC_RS2_SEL(DEC_RS2_SEL),
    .DEC_RS1_USE(DEC_RS1_USE), .DEC_RS2_USE(DEC_RS2_USE), .DEC_RD(DEC_RD),
    .DEC_RD_VALID(DEC_RD_VALID), .DEC_READY(DEC_READY),
    .RS1_SEL(RS1_SEL), .RS2_SEL(RS2_SEL),
    .RS1_DATAIN(RS1_DATAIN), .RS2_DATAIN(RS2_DATAIN), .DATA_IN(DATA_IN),
    .RD_WB_VALID_MEM3_WB(RD_WB_VALID_MEM3_WB), .RD_WB_MEM3_WB(RD_WB_MEM3_WB),
    .RETIRE_VALID(RETIRE_VALID), .RETIRE_RD(RETIRE_RD), .FLUSH(FLUSH),
    .EX_READY(EX_READY), .EX_VALID(EX_VALID), .EX_RS1_DATA(EX_RS1_DATA),
    .EX_RS2_DATA(EX_RS2_DATA), .EX_RD(EX_RD), .EX_RD_VALID(EX_RD_VALID),
    .SB_ERR(SB_ERR)
  );

  always #5 CLK = ~CLK;

  // Safety net in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    DEC_VALID = 0; DEC_RS1_SEL = 0; DEC_RS2_SEL = 0; DEC_RS1_USE = 0; DEC_RS2_USE = 0;
    DEC_RD = 0; DEC_RD_VALID = 0; RS1_DATAIN = 0; RS2_DATAIN = 0; DATA_IN = 0;
    RD_WB_VALID_MEM3_WB = 0; RD_WB_MEM3_WB = 0; RETIRE_VALID = 0; RETIRE_RD = 0;
    FLUSH = 0; EX_READY = 1;
  endtask

  task automatic present(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rdv);
    DEC_VALID = 1; DEC_RS1_SEL = rs1; DEC_RS1_USE = u1; DEC_RS2_SEL = rs2;
    DEC_RS2_USE = u2; DEC_RD = rd; DEC_RD_VALID = rdv;
  endtask

  task automatic retire(input logic [4:0] rd);
    RETIRE_VALID = 1; RETIRE_RD = rd;
  endtask

  task automatic test_reset();
    RST = 1; set_idle();
    present(5'd1, 1, 5'd2, 1, 5'd5, 1);
    cyc(); cyc();
    n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", DEC_READY); end
    n_tests++; if (EX_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", EX_VALID); end
    n_tests++; if (SB_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", SB_ERR); end
    n_tests++; if ({EX_RS1_DATA, EX_RS2_DATA, EX_RD, EX_RD_VALID} !== 134'd0) begin
      n_fail++; $display("FAIL rst_data: got %h %h %h %b want all 0", EX_RS1_DATA, EX_RS2_DATA, EX_RD, EX_RD_VALID); end
    RST = 0; RS1_DATAIN = 64'd10; RS2_DATAIN = 64'd20;
    #1;
    n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b want 1", DEC_READY); end
    n_tests++; if (RS1_SEL !== 5'd1 || RS2_SEL !== 5'd2) begin n_fail++; $display("FAIL sel: got %0d %0d want 1 2", RS1_SEL, RS2_SEL); end
    cyc();
    n_tests++; if (EX_VALID !== 1'b1 || EX_RS1_DATA !== 64'd10 || EX_RS2_DATA !== 64'd20 || EX_RD !== 5'd5 || EX_RD_VALID !== 1'b1) begin
      n_fail++; $display("FAIL add_slot: got v=%b %0d %0d rd=%0d rv=%b want 1 10 20 5 1", EX_VALID, EX_RS1_DATA, EX_RS2_DATA, EX_RD, EX_RD_VALID); end
    // x5 now has one outstanding write: a reader of x5 must stall.
    present(5'd5, 1, 5'd0, 0, 5'd0, 0);
    #1;
    n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL cnt5_busy: got %b want 0", DEC_READY); end
    DEC_VALID = 0; retire(5'd5);
    cyc();
    set_idle();
  endtask

  task automatic test_raw_bypass();
    present(5'd0, 0, 5'd0, 0, 5'd5, 1);
    #1;
    n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL raw_prod_ready: got %b want 1", DEC_READY); end
    cyc();
    present(5'd5, 1, 5'd0, 0, 5'd6, 1); RS1_DATAIN = 64'h1111;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL raw_stall%0d: got %b want 0", i, DEC_READY); end
      cyc();
    end
    retire(5'd5); RD_WB_VALID_MEM3_WB = 1; RD_WB_MEM3_WB = 5'd5; DATA_IN = 64'hDEADBEEF_00000001;
    #1;
    n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL raw_wake: got %b want 1", DEC_READY); end
    cyc();
    set_idle(); retire(5'd6);
    #1;
    n_tests++; if (EX_VALID !== 1'b1 || EX_RS1_DATA !== 64'hDEADBEEF_00000001 || EX_RD !== 5'd6) begin
      n_fail++; $display("FAIL raw_bypass: got v=%b %h rd=%0d want 1 deadbeef00000001 6", EX_VALID, EX_RS1_DATA, EX_RD); end
    cyc();
    set_idle();
  endtask

  task automatic test_saturation();
    present(5'd0, 0, 5'd0, 0, 5'd7, 1);
    for (int i = 0; i < 7; i++) begin
      #1;
      n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL sat_issue%0d: got %b want 1", i, DEC_READY); end
      cyc();
    end
    #1;
    n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL sat_full: got %b want 0", DEC_READY); end
    cyc();
    retire(5'd7);
    #1;
    n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL sat_no_credit: got %b want 0", DEC_READY); end
    cyc();
    RETIRE_VALID = 0;
    #1;
    n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL sat_reissue: got %b want 1", DEC_READY); end
    cyc();
    DEC_VALID = 0;
    for (int i = 0; i < 7; i++) begin retire(5'd7); cyc(); end
    set_idle();
  endtask

  task automatic test_simultaneous();
    present(5'd0, 0, 5'd0, 0, 5'd9, 1);
    cyc(); cyc();
    // cnt[9]=2, slot holds the second rd=9 producer.
    retire(5'd9); FLUSH = 1;
    #1;
    n_tests++; if (DEC_READY !== 1'b0) begin n_fail++; $display("FAIL sim_flush_blocks: got %b want 0", DEC_READY); end
    cyc();
    set_idle();
    present(5'd9, 1, 5'd0, 0, 5'd0, 0);
    #1;
    n_tests++; if (EX_VALID !== 1'b0) begin n_fail++; $display("FAIL sim_slot_squashed: got %b want 0", EX_VALID); end
    n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL sim_cnt9_zero: got %b want 1", DEC_READY); end
    n_tests++; if (SB_ERR !== 1'b0) begin n_fail++; $display("FAIL sim_err: got %b want 0", SB_ERR); end
    cyc();
    set_idle(); cyc();
  endtask

  task automatic test_backpressure();
    present(5'd1, 1, 5'd0, 0, 5'd3, 1); RS1_DATAIN = 64'hAAA;
    cyc();
    EX_READY = 0;
    present(5'd2, 1, 5'd0, 0, 5'd4, 1); RS1_DATAIN = 64'hBBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (EX_VALID !== 1'b1 || EX_RS1_DATA !== 64'hAAA || EX_RD !== 5'd3 || DEC_READY !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b %h rd=%0d rdy=%b want 1 aaa 3 0", i, EX_VALID, EX_RS1_DATA, EX_RD, DEC_READY); end
      cyc();
    end
    EX_READY = 1;
    #1;
    n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", DEC_READY); end
    cyc();
    set_idle(); retire(5'd3);
    #1;
    n_tests++; if (EX_VALID !== 1'b1 || EX_RS1_DATA !== 64'hBBB || EX_RD !== 5'd4) begin
      n_fail++; $display("FAIL bp_load: got v=%b %h rd=%0d want 1 bbb 4", EX_VALID, EX_RS1_DATA, EX_RD); end
    cyc();
    retire(5'd4); cyc();
    set_idle();
  endtask

  task automatic test_error_x0();
    retire(5'd12);
    cyc();
    set_idle();
    present(5'd12, 1, 5'd0, 0, 5'd0, 0);
    #1;
    n_tests++; if (SB_ERR !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", SB_ERR); end
    n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL err_cnt12_zero: got %b want 1", DEC_READY); end
    cyc();
    present(5'd0, 0, 5'd0, 0, 5'd0, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (DEC_READY !== 1'b1) begin n_fail++; $display("FAIL x0_rd_ready%0d: got %b want 1", i, DEC_READY); end
      cyc();
      n_tests++; if (EX_VALID !== 1'b1 || EX_RD_VALID !== 1'b0) begin
        n_fail++; $display("FAIL x0_rd_valid%0d: got v=%b rv=%b want 1 0", i, EX_VALID, EX_RD_VALID); end
    end
    present(5'd0, 1, 5'd0, 0, 5'd0, 0);
    RS1_DATAIN = 64'd0; RD_WB_VALID_MEM3_WB = 1; RD_WB_MEM3_WB = 5'd0; DATA_IN = '1;
    cyc();
    set_idle();
    #1;
    n_tests++; if (EX_RS1_DATA !== 64'd0) begin n_fail++; $display("FAIL x0_read: got %h want 0", EX_RS1_DATA); end
    n_tests++; if (SB_ERR !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", SB_ERR); end
    cyc();
  endtask

  task automatic test_mid_reset();
    present(5'd0, 0, 5'd0, 0, 5'd5, 1);
    cyc();
    set_idle(); RST = 1;
    cyc();
    RST = 0;
    #1;
    n_tests++; if (SB_ERR !== 1'b0 || EX_VALID !== 1'b0) begin
      n_fail++; $display("FAIL mrst_clear: got err=%b v=%b want 0 0", SB_ERR, EX_VALID); end
    // Retirement of the pre-reset producer now underflows.
    retire(5'd5);
    cyc();
    set_idle();
    #1;
    n_tests++; if (SB_ERR !== 1'b1) begin n_fail++; $display("FAIL mrst_stale_retire: got %b want 1", SB_ERR); end
  endtask

  initial begin
    test_reset();
    test_raw_bypass();
    test_saturation();
    test_simultaneous();
    test_backpressure();
    test_error_x0();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
